csa_resolve_serial: RTL and testbench



---
 rtl/csa_resolve_serial.sv | 107 ++++++++++
 tb/tb_csa_resolve_serial.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_serial.sv
// Digit-serial final adder for carry-save pairs: resolves S + C DIGIT bits per clock.
// Optional out_parity output enabled by defining CSA_RESOLVE_PARITY_EN.
module csa_resolve_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CSA_RESOLVE_PARITY_EN
    output logic             out_parity,
`endif
    output logic [WIDTH:0]   out_sum
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   s_q;
    logic [WIDTH-1:0]   c_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DIGIT:0]     step;
    logic [WIDTH-1:0]   res_next;
    logic               last;
`ifdef CSA_RESOLVE_PARITY_EN
    logic               par_q;
`endif

    // One DIGIT-bit adder slice; each new digit enters the result from the top.
    always_comb begin
        step     = {1'b0, s_q[DIGIT-1:0]} + {1'b0, c_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
        res_next = (res_q >> DIGIT) | (WIDTH'(step[DIGIT-1:0]) << (WIDTH - DIGIT));
        last     = (cnt_q == CNT_W'(N - 1));
        in_ready = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_q       <= '0;
            c_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
`ifdef CSA_RESOLVE_PARITY_EN
            par_q      <= 1'b0;
            out_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_q     <= in_s;
                        c_q     <= in_c;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
`ifdef CSA_RESOLVE_PARITY_EN
                        par_q   <= 1'b0;
`endif
                        state   <= RUN;
                    end
                end
                RUN: begin
                    s_q     <= s_q >> DIGIT;
                    c_q     <= c_q >> DIGIT;
                    carry_q <= step[DIGIT];
                    res_q   <= res_next;
                    if (cnt_q != CNT_W'(N))
                        cnt_q <= cnt_q + 1'b1;
`ifdef CSA_RESOLVE_PARITY_EN
                    par_q   <= par_q ^ (^step[DIGIT-1:0]);
`endif
                    // Final digit: the slice carry-out becomes the result MSB.
                    if (last) begin
                        out_sum   <= {step[DIGIT], res_next};
                        out_valid <= 1'b1;
`ifdef CSA_RESOLVE_PARITY_EN
                        out_parity <= par_q ^ (^step);
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolve_serial.sv
// Self-checking bench for csa_resolve_serial: DIGIT=2 directed tests plus DIGIT=1/8 random sweeps.
// Parity checks are active when CSA_RESOLVE_PARITY_EN is defined.
module tb_csa_resolve_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv   [3];
    logic       ir   [3];
    logic [7:0] s_in [3];
    logic [7:0] c_in [3];
    logic       ov   [3];
    logic       ordy [3];
    logic [8:0] sum  [3];
`ifdef CSA_RESOLVE_PARITY_EN
    logic       par  [3];
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat_exp [3] = '{4, 8, 1};

    always #5 clk = ~clk;

    csa_resolve_serial #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_s(s_in[0]), .in_c(c_in[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
`ifdef CSA_RESOLVE_PARITY_EN
        .out_parity(par[0]),
`endif
        .out_sum(sum[0]));

    csa_resolve_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_s(s_in[1]), .in_c(c_in[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
`ifdef CSA_RESOLVE_PARITY_EN
        .out_parity(par[1]),
`endif
        .out_sum(sum[1]));

    csa_resolve_serial #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_s(s_in[2]), .in_c(c_in[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
`ifdef CSA_RESOLVE_PARITY_EN
        .out_parity(par[2]),
`endif
        .out_sum(sum[2]));

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic [8:0] sum;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on DUT d: accept, wait for result, hold out_ready low for 'hold' cycles.
    task automatic xfer(input int d, input logic [7:0] s, input logic [7:0] c, input int hold,
                        output logic [8:0] got, output logic gp, output int lat);
        int g = 0;
        while (!ir[d] && g < 40) begin
            tick();
            g++;
        end
        s_in[d] = s;
        c_in[d] = c;
        iv[d]   = 1'b1;
        tick();
        iv[d]   = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 40) begin
            tick();
            lat++;
        end
        got = sum[d];
`ifdef CSA_RESOLVE_PARITY_EN
        gp = par[d];
`else
        gp = 1'b0;
`endif
        repeat (hold) tick();
        ordy[d] = 1'b1;
        tick();
        ordy[d] = 1'b0;
    endtask

    logic [8:0] got;
    logic [8:0] expv;
    logic       gp;
    int         lat;
    logic [8:0] res [2];
    int         acc_t [2];
    int         nacc, nres, cyc, seen;
    logic       acc, dn;
    logic [8:0] smp;
    logic [7:0] rs, rc;

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; s_in[i] = '0; c_in[i] = '0;
        end
        tbl[0] = '{8'h00, 8'h00, 9'h000};
        tbl[1] = '{8'hFF, 8'h01, 9'h100};
        tbl[2] = '{8'hFF, 8'hFF, 9'h1FE};
        tbl[3] = '{8'h5A, 8'h33, 9'h08D};
        tbl[4] = '{8'h0A, 8'h0A, 9'h014};
        tbl[5] = '{8'h04, 8'h12, 9'h016};
        tbl[6] = '{8'h07, 8'h08, 9'h00F};
        tbl[7] = '{8'h80, 8'h80, 9'h100};
        tbl[8] = '{8'hAA, 8'h55, 9'h0FF};
        tbl[9] = '{8'h3C, 8'h0F, 9'h04B};

        repeat (3) tick();
        chk("reset_in_ready", 32'(ir[0]), 1);
        chk("reset_out_valid", 32'(ov[0]), 0);
        chk("reset_out_sum", 32'(sum[0]), 0);
`ifdef CSA_RESOLVE_PARITY_EN
        chk("reset_parity", 32'(par[0]), 0);
`endif
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_in_ready", 32'(ir[0]), 1);
        chk("idle_out_valid", 32'(ov[0]), 0);

        // Directed table on the DIGIT=2 instance.
        for (int i = 0; i < 10; i++) begin
            xfer(0, tbl[i].s, tbl[i].c, 0, got, gp, lat);
            chk($sformatf("tbl%0d_sum", i), 32'(got), 32'(tbl[i].sum));
            chk($sformatf("tbl%0d_lat", i), lat, 4);
`ifdef CSA_RESOLVE_PARITY_EN
            chk($sformatf("tbl%0d_par", i), 32'(gp), 32'(^tbl[i].sum));
`endif
        end

        // Backpressure hold with an ignored in_valid pulse.
        s_in[0] = 8'h5A; c_in[0] = 8'h33; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        chk("run_in_ready", 32'(ir[0]), 0);
        lat = 0;
        while (!ov[0] && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp_lat", lat, 4);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                s_in[0] = 8'h11; c_in[0] = 8'h22; iv[0] = 1'b1;
            end else begin
                iv[0] = 1'b0;
            end
            chk($sformatf("bp_hold%0d_valid", i), 32'(ov[0]), 1);
            chk($sformatf("bp_hold%0d_sum", i), 32'(sum[0]), 32'h08D);
            chk($sformatf("bp_hold%0d_ready", i), 32'(ir[0]), 0);
            tick();
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        chk("bp_release_valid", 32'(ov[0]), 0);
        chk("bp_release_ready", 32'(ir[0]), 1);
        seen = 0;
        repeat (8) begin
            tick();
            if (ov[0] || !ir[0]) seen++;
        end
        chk("bp_ignored_pulse", seen, 0);

        // Back-to-back with in_valid held high and out_ready high.
        s_in[0] = 8'h0A; c_in[0] = 8'h0A; iv[0] = 1'b1; ordy[0] = 1'b1;
        nacc = 0; nres = 0; cyc = 0;
        acc_t[0] = 0; acc_t[1] = 0; res[0] = '0; res[1] = '0;
        while (nres < 2 && cyc < 60) begin
            acc = iv[0] && ir[0];
            dn  = ov[0] && ordy[0];
            smp = sum[0];
            tick();
            cyc++;
            if (acc && nacc < 2) begin
                acc_t[nacc] = cyc;
                nacc++;
                if (nacc == 1) begin
                    s_in[0] = 8'h04; c_in[0] = 8'h12;
                end else begin
                    iv[0] = 1'b0;
                end
            end
            if (dn && nres < 2) begin
                res[nres] = smp;
                nres++;
            end
        end
        iv[0] = 1'b0; ordy[0] = 1'b0;
        chk("b2b_count", nres, 2);
        chk("b2b_res0", 32'(res[0]), 32'h014);
        chk("b2b_res1", 32'(res[1]), 32'h016);
        chk("b2b_spacing", acc_t[1] - acc_t[0], 6);

        // Reset two cycles into an operation.
        tick();
        s_in[0] = 8'hFF; c_in[0] = 8'hFF; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(ov[0]), 0);
        chk("rst_mid_ready", 32'(ir[0]), 1);
        chk("rst_mid_sum", 32'(sum[0]), 0);
        tick();
        tick();
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (ov[0]) seen++;
        end
        ordy[0] = 1'b0;
        chk("rst_no_emit", seen, 0);
        xfer(0, 8'h07, 8'h08, 0, got, gp, lat);
        chk("post_rst_sum", 32'(got), 32'h00F);
        chk("post_rst_lat", lat, 4);

        // Random sweeps on DIGIT=1 and DIGIT=8 against plain addition.
        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 500; i++) begin
                rs = 8'($urandom);
                rc = 8'($urandom);
                xfer(d, rs, rc, $urandom_range(0, 2), got, gp, lat);
                expv = {1'b0, rs} + {1'b0, rc};
                chk($sformatf("rnd_d%0d_%0d_sum", d, i), 32'(got), 32'(expv));
                chk($sformatf("rnd_d%0d_%0d_lat", d, i), lat, lat_exp[d]);
`ifdef CSA_RESOLVE_PARITY_EN
                chk($sformatf("rnd_d%0d_%0d_par", d, i), 32'(gp), 32'(^expv));
`endif
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
